// File: rtl/xpb_gen_table.sv
// xpb_gen_table: run-time programmable XPB constant table.
// Generates T[j] = j*B mod M with one modular add per cycle and serves NUM_CH read channels.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   start           one-cycle pulse; samples base_in/mod_in and starts generation
//   base_in/mod_in  base B and modulus M (WORD_BITS each)
//   busy            high while the table is being generated
//   ready           high while the table is complete and valid
//   done            one-cycle pulse when generation completes
//   base_err        sticky flag: the last start had B >= M or M == 0
//   rd_en/rd_idx    per-channel read request and index (IDX_BITS per channel)
//   rd_data         per-channel table entry (WORD_BITS per channel), 1-cycle latency
//   rd_valid        per-channel data-valid flag
module xpb_gen_table #(
    parameter int WORD_BITS = 1024,
    parameter int IDX_BITS  = 5,
    parameter int NUM_CH    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [WORD_BITS-1:0]          base_in,
    input  logic [WORD_BITS-1:0]          mod_in,
    output logic                          busy,
    output logic                          ready,
    output logic                          done,
    output logic                          base_err,
    input  logic [NUM_CH-1:0]             rd_en,
    input  logic [NUM_CH*IDX_BITS-1:0]    rd_idx,
    output logic [NUM_CH*WORD_BITS-1:0]   rd_data,
    output logic [NUM_CH-1:0]             rd_valid
);

    localparam int DEPTH = 1 << IDX_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        READY = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WORD_BITS-1:0] b_q;
    logic [WORD_BITS-1:0] m_q;
    logic [WORD_BITS-1:0] acc;
    logic [IDX_BITS-1:0]  j;

    logic [WORD_BITS:0]   sum;
    logic [WORD_BITS-1:0] diff;
    logic [WORD_BITS-1:0] entry;
    logic                 start_ok;
    logic                 last;
    logic                 gen_we;

    // Entry 0 is always zero, so only entries 1..DEPTH-1 are stored.
    logic [WORD_BITS-1:0] tbl [1:DEPTH-1];

    logic [IDX_BITS-1:0]  idx_c  [NUM_CH];
    logic [WORD_BITS-1:0] word_c [NUM_CH];

    assign start_ok = start && (mod_in != '0) && (base_in < mod_in);
    assign last     = (j == IDX_BITS'(DEPTH - 1));
    assign gen_we   = (state == GEN) && !start;

    // acc < M and B < M, so s < 2M and one conditional subtract reduces it.
    // s - M < M fits in WORD_BITS, so the truncated subtraction is exact.
    always_comb begin
        sum   = {1'b0, acc} + {1'b0, b_q};
        diff  = sum[WORD_BITS-1:0] - m_q;
        entry = (sum >= {1'b0, m_q}) ? diff : sum[WORD_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Any start (valid or not) overrides the current state; an invalid one
    // discards the table and parks in IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = GEN;
                end
            end
            GEN: begin
                if (start) begin
                    state_nxt = start_ok ? GEN : IDLE;
                end else if (last) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                if (start) begin
                    state_nxt = start_ok ? GEN : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy  = (state == GEN);
    assign ready = (state == READY);

    always_ff @(posedge clk) begin
        if (reset) begin
            b_q      <= '0;
            m_q      <= '0;
            acc      <= '0;
            j        <= '0;
            done     <= 1'b0;
            base_err <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                if (start_ok) begin
                    b_q      <= base_in;
                    m_q      <= mod_in;
                    acc      <= '0;
                    j        <= IDX_BITS'(1);
                    base_err <= 1'b0;
                end else begin
                    base_err <= 1'b1;
                end
            end else if (gen_we) begin
                acc <= entry;
                j   <= j + IDX_BITS'(1);
                if (last) begin
                    done <= 1'b1;
                end
            end
        end
    end

    // Storage has no reset; j never equals 0 while generating.
    always_ff @(posedge clk) begin
        if (gen_we) begin
            tbl[j] <= entry;
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            idx_c[c]  = rd_idx[c*IDX_BITS +: IDX_BITS];
            word_c[c] = (idx_c[c] == '0) ? '0 : tbl[idx_c[c]];
        end
    end

    // Reads see the table as it stands at the sampling edge, so a read
    // issued with an accepted start still returns the previous table.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (rd_en[c]) begin
                    rd_valid[c] <= ready;
                    rd_data[c*WORD_BITS +: WORD_BITS] <= ready ? word_c[c] : '0;
                end else begin
                    rd_valid[c] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_xpb_gen_table.sv
// tb_xpb_gen_table: self-checking bench for xpb_gen_table.
// Drives a 16/3/2 instance and a default 1024/5/1 instance with scoreboarded reads.
module tb_xpb_gen_table;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // Small instance: WORD_BITS=16, IDX_BITS=3, NUM_CH=2
    logic        s_go = 1'b0;
    logic [15:0] s_base = '0;
    logic [15:0] s_mod = '0;
    logic        s_busy, s_ready, s_done, s_base_err;
    logic [1:0]  s_rd_en = '0;
    logic [5:0]  s_rd_idx = '0;
    logic [31:0] s_rd_data;
    logic [1:0]  s_rd_valid;

    xpb_gen_table #(.WORD_BITS(16), .IDX_BITS(3), .NUM_CH(2)) u_small (
        .clk      (clk),
        .reset    (reset),
        .start    (s_go),
        .base_in  (s_base),
        .mod_in   (s_mod),
        .busy     (s_busy),
        .ready    (s_ready),
        .done     (s_done),
        .base_err (s_base_err),
        .rd_en    (s_rd_en),
        .rd_idx   (s_rd_idx),
        .rd_data  (s_rd_data),
        .rd_valid (s_rd_valid)
    );

    // Wide instance: defaults 1024/5/1
    logic          w_go = 1'b0;
    logic [1023:0] w_base = '0;
    logic [1023:0] w_mod = '0;
    logic          w_busy, w_ready, w_done, w_base_err;
    logic [0:0]    w_rd_en = '0;
    logic [4:0]    w_rd_idx = '0;
    logic [1023:0] w_rd_data;
    logic [0:0]    w_rd_valid;

    xpb_gen_table u_wide (
        .clk      (clk),
        .reset    (reset),
        .start    (w_go),
        .base_in  (w_base),
        .mod_in   (w_mod),
        .busy     (w_busy),
        .ready    (w_ready),
        .done     (w_done),
        .base_err (w_base_err),
        .rd_en    (w_rd_en),
        .rd_idx   (w_rd_idx),
        .rd_data  (w_rd_data),
        .rd_valid (w_rd_valid)
    );

    typedef struct {
        int          ch;
        logic        v;
        logic [15:0] d;
    } s_exp_t;

    typedef struct {
        int            idx;
        logic [1023:0] d;
    } w_exp_t;

    s_exp_t sq[$];
    w_exp_t wq[$];

    logic [15:0] mt [8];
    logic        exp_rdy = 1'b0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void set_model(input int b, input int m);
        for (int k = 0; k < 8; k++) begin
            mt[k] = 16'((k * b) % m);
        end
    endfunction

    task automatic s_read(input logic [1:0] en, input int i0, input int i1);
        s_exp_t e;
        s_rd_en  = en;
        s_rd_idx = {3'(i1), 3'(i0)};
        for (int c = 0; c < 2; c++) begin
            if (en[c]) begin
                e.ch = c;
                e.v  = exp_rdy;
                e.d  = exp_rdy ? mt[(c == 0) ? i0 : i1] : 16'h0000;
                sq.push_back(e);
            end
        end
        tick();
        s_rd_en = '0;
        while (sq.size() > 0) begin
            e = sq.pop_front();
            n_run++;
            if (s_rd_valid[e.ch] !== e.v || s_rd_data[e.ch*16 +: 16] !== e.d) begin
                n_fail++;
                $display("FAIL rd_ch%0d idx=%0d: got v=%b d=%h, want v=%b d=%h",
                         e.ch, (e.ch == 0) ? i0 : i1, s_rd_valid[e.ch],
                         s_rd_data[e.ch*16 +: 16], e.v, e.d);
            end
        end
    endtask

    task automatic s_start(input logic [15:0] b, input logic [15:0] m);
        s_base = b;
        s_mod  = m;
        s_go   = 1'b1;
        tick();
        s_go   = 1'b0;
    endtask

    // Called in cycle 1 after an accepted start; leaves us in cycle 9.
    task automatic s_gen_check(input string nm);
        for (int k = 1; k < 8; k++) begin
            n_run++;
            if ({s_busy, s_ready, s_done, s_base_err} !== 4'b1000) begin
                n_fail++;
                $display("FAIL %s cyc%0d: got bsy/rdy/done/err=%b, want 1000",
                         nm, k, {s_busy, s_ready, s_done, s_base_err});
            end
            tick();
        end
        n_run++;
        if ({s_busy, s_ready, s_done, s_base_err} !== 4'b0110) begin
            n_fail++;
            $display("FAIL %s cyc8: got bsy/rdy/done/err=%b, want 0110",
                     nm, {s_busy, s_ready, s_done, s_base_err});
        end
        tick();
        n_run++;
        if ({s_ready, s_done} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s cyc9: got rdy/done=%b, want 10", nm, {s_ready, s_done});
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        n_run++;
        if ({s_busy, s_ready, s_done, s_base_err, s_rd_valid, s_rd_data} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_small: got %h, want 0",
                     {s_busy, s_ready, s_done, s_base_err, s_rd_valid, s_rd_data});
        end
        n_run++;
        if ({w_busy, w_ready, w_done, w_base_err, w_rd_valid} !== 5'd0 || w_rd_data !== '0) begin
            n_fail++;
            $display("FAIL reset_wide: got flags=%b data_lo=%h, want 0",
                     {w_busy, w_ready, w_done, w_base_err, w_rd_valid}, w_rd_data[63:0]);
        end
        reset = 1'b0;
        tick();
        exp_rdy = 1'b0;
        s_read(2'b11, 1, 2);
    endtask

    task automatic test_gen_basic;
        s_start(16'h0064, 16'h00FB);
        s_gen_check("gen_basic");
        set_model(16'h0064, 16'h00FB);
        exp_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_read(2'b01, k, 0);
        end
        tick();
        n_run++;
        if (s_rd_valid[0] !== 1'b0 || s_rd_data[15:0] !== mt[7]) begin
            n_fail++;
            $display("FAIL rd_hold: got v=%b d=%h, want v=0 d=%h",
                     s_rd_valid[0], s_rd_data[15:0], mt[7]);
        end
    endtask

    task automatic test_dual;
        s_read(2'b11, 5, 5);
        s_read(2'b11, 3, 6);
        s_read(2'b10, 0, 7);
    endtask

    task automatic test_base_err;
        s_start(16'h00FB, 16'h00FB);
        n_run++;
        if ({s_busy, s_ready, s_done, s_base_err} !== 4'b0001) begin
            n_fail++;
            $display("FAIL base_err: got bsy/rdy/done/err=%b, want 0001",
                     {s_busy, s_ready, s_done, s_base_err});
        end
        exp_rdy = 1'b0;
        s_read(2'b01, 1, 0);
        n_run++;
        if ({s_busy, s_ready, s_done, s_base_err} !== 4'b0001) begin
            n_fail++;
            $display("FAIL base_err_hold: got %b, want 0001",
                     {s_busy, s_ready, s_done, s_base_err});
        end
        s_start(16'h0001, 16'h0007);
        s_gen_check("gen_after_err");
        set_model(1, 7);
        exp_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_read(2'b01, k, 0);
        end
    endtask

    task automatic test_restart;
        s_exp_t e;
        // Read issued alongside the start must return the old (1,7) table.
        e.ch = 0;
        e.v  = 1'b1;
        e.d  = mt[5];
        sq.push_back(e);
        s_rd_en  = 2'b01;
        s_rd_idx = 6'd5;
        s_base   = 16'h0064;
        s_mod    = 16'h00FB;
        s_go     = 1'b1;
        tick();
        s_go    = 1'b0;
        s_rd_en = '0;
        e = sq.pop_front();
        n_run++;
        if (s_rd_valid[0] !== e.v || s_rd_data[15:0] !== e.d) begin
            n_fail++;
            $display("FAIL rd_at_start: got v=%b d=%h, want v=%b d=%h",
                     s_rd_valid[0], s_rd_data[15:0], e.v, e.d);
        end
        for (int k = 1; k < 4; k++) begin
            n_run++;
            if ({s_busy, s_ready, s_done} !== 3'b100) begin
                n_fail++;
                $display("FAIL restart_first cyc%0d: got %b, want 100",
                         k, {s_busy, s_ready, s_done});
            end
            tick();
        end
        s_start(16'h0002, 16'h0009);
        s_gen_check("restart");
        set_model(2, 9);
        exp_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_read(2'b10, 0, k);
        end
    endtask

    task automatic test_reset_gen;
        s_start(16'h0064, 16'h00FB);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_run++;
        if ({s_busy, s_ready, s_done, s_rd_valid, s_rd_data} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_gen: got %h, want 0",
                     {s_busy, s_ready, s_done, s_rd_valid, s_rd_data});
        end
        exp_rdy = 1'b0;
        s_read(2'b11, 3, 7);
        for (int k = 0; k < 8; k++) begin
            tick();
        end
        n_run++;
        if ({s_busy, s_ready, s_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_gen_idle: got %b, want 000", {s_busy, s_ready, s_done});
        end
        s_read(2'b01, 5, 0);
    endtask

    task automatic test_wide;
        logic [1029:0] prod;
        w_exp_t        e;
        for (int w = 0; w < 32; w++) begin
            w_mod[w*32 +: 32]  = $urandom;
            w_base[w*32 +: 32] = $urandom;
        end
        w_mod[1023] = 1'b1;
        w_base = w_base % w_mod;
        w_go = 1'b1;
        tick();
        w_go = 1'b0;
        for (int k = 1; k < 32; k++) begin
            n_run++;
            if ({w_busy, w_ready, w_done} !== 3'b100) begin
                n_fail++;
                $display("FAIL wide_gen cyc%0d: got %b, want 100", k, {w_busy, w_ready, w_done});
            end
            tick();
        end
        n_run++;
        if ({w_busy, w_ready, w_done, w_base_err} !== 4'b0110) begin
            n_fail++;
            $display("FAIL wide_gen cyc32: got %b, want 0110",
                     {w_busy, w_ready, w_done, w_base_err});
        end
        for (int k = 0; k < 32; k++) begin
            prod  = 1030'(k) * {6'b0, w_base};
            prod  = prod % {6'b0, w_mod};
            e.idx = k;
            e.d   = prod[1023:0];
            wq.push_back(e);
            w_rd_en  = 1'b1;
            w_rd_idx = 5'(k);
            tick();
            w_rd_en = 1'b0;
            e = wq.pop_front();
            n_run++;
            if (w_rd_valid !== 1'b1 || w_rd_data !== e.d) begin
                n_fail++;
                $display("FAIL wide_rd idx=%0d: got v=%b d_lo=%h, want v=1 d_lo=%h",
                         e.idx, w_rd_valid, w_rd_data[63:0], e.d[63:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_gen_basic();
        test_dual();
        test_base_err();
        test_restart();
        test_reset_gen();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
